regfile_access_arbiter: RTL and testbench

- Shares one 8-entry N-bit register file between two requesters (port 0, port 1).
- Issues at most one read or write per cycle to the register file.
- Grants round-robin between the ports, and supports a bounded lock so one requester can issue back-to-back operations.
- Routes each read's result back to the requester that issued it, one cycle after the grant.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_access_arbiter_rr_pick2.sv | 30 +++
 rtl/regfile_access_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_access_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state encoding for the register file arbiter
package regfile_pkg;

    localparam int N_DEFAULT         = 16;
    localparam int ADDR_W_DEFAULT    = 3;
    localparam int MAX_BURST_DEFAULT = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_OWN0 = 2'd1;
    localparam state_t ST_OWN1 = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/regfile_access_arbiter_rr_pick2.sv
// rtl/regfile_access_arbiter_rr_pick2.sv - two-way round-robin winner selection with lock ownership
module rr_pick2
    import regfile_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    input  logic       own_valid_i,
    input  logic       owner_i,
    input  logic       force_i,
    output logic [1:0] gnt_o
);

    // Owner keeps the grant unless its burst is exhausted and the other side waits;
    // otherwise a lone requester wins and a tie goes to the port not granted last.
    always_comb begin
        gnt_o = 2'b00;
        if (own_valid_i && req_i[owner_i]) begin
            if (force_i && req_i[~owner_i]) begin
                gnt_o[~owner_i] = 1'b1;
            end else begin
                gnt_o[owner_i] = 1'b1;
            end
        end else if (req_i[PORT0] && req_i[PORT1]) begin
            gnt_o[~last_gnt_i] = 1'b1;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - two-port arbiter sharing one register file with bounded lock bursts
module regfile_access_arbiter
    import regfile_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [N-1:0]      wdata0,
    input  logic [N-1:0]      wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [N-1:0]      rdata0,
    output logic [N-1:0]      rdata1,
    output logic              rf_read_enable,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_read_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [N-1:0]      rf_write_data,
    input  logic [N-1:0]      rf_read_data
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_owner_q, rd_owner_d;

    logic               own_valid;
    logic               owner;
    logic               force_rot;
    logic [1:0]         pick;
    logic               win;
    logic               win_port;
    logic               win_we;
    logic               win_lock;
    logic [ADDR_W-1:0]  win_addr;

    assign own_valid = (state_q != ST_IDLE);
    assign owner     = (state_q == ST_OWN1);
    assign force_rot = (burst_q == CNT_W'(MAX_BURST));

    rr_pick2 u_pick (
        .req_i       ({req1, req0}),
        .last_gnt_i  (last_gnt_q),
        .own_valid_i (own_valid),
        .owner_i     (owner),
        .force_i     (force_rot),
        .gnt_o       (pick)
    );

    // Grants are masked while reset is held so nothing reaches the register file.
    assign gnt0     = pick[PORT0] & ~rst;
    assign gnt1     = pick[PORT1] & ~rst;
    assign win      = gnt0 | gnt1;
    assign win_port = gnt1;
    assign win_we   = win_port ? we1 : we0;
    assign win_lock = win_port ? lock1 : lock0;
    assign win_addr = win_port ? addr1 : addr0;

    assign rf_write_enable = win & win_we;
    assign rf_read_enable  = win & ~win_we;
    assign rf_read_addr    = win_addr;
    assign rf_write_addr   = win_addr;
    assign rf_write_data   = win_port ? wdata1 : wdata0;

    assign rvalid0 = rd_pend_q & (rd_owner_q == PORT0) & ~rst;
    assign rvalid1 = rd_pend_q & (rd_owner_q == PORT1) & ~rst;
    assign rdata0  = rf_read_data;
    assign rdata1  = rf_read_data;

    // Ownership, burst counting and read-return tracking for the next cycle.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        burst_d    = burst_q;
        rd_pend_d  = rf_read_enable;
        rd_owner_d = win_port;
        if (win) begin
            last_gnt_d = win_port;
            if (win_lock) begin
                state_d = win_port ? ST_OWN1 : ST_OWN0;
                if (own_valid && (owner == win_port)) begin
                    burst_d = force_rot ? burst_q : burst_q + CNT_W'(1);
                end else begin
                    burst_d = CNT_W'(1);
                end
            end else begin
                state_d = ST_IDLE;
                burst_d = '0;
            end
        end else if (own_valid) begin
            // No grant at all means the owner has let go of its request.
            state_d = ST_IDLE;
            burst_d = '0;
        end
    end

    // State registers; port 0 wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= PORT1;
            burst_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            burst_q    <= burst_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb/tb_regfile_access_arbiter.sv - scoreboard bench for regfile_access_arbiter
module tb_regfile_access_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [2:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        rf_read_enable, rf_write_enable;
    logic [2:0]  rf_read_addr, rf_write_addr;
    logic [15:0] rf_write_data;
    logic [15:0] rf_read_data;

    regfile_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .rf_read_enable(rf_read_enable), .rf_write_enable(rf_write_enable),
        .rf_read_addr(rf_read_addr), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Register file environment: synchronous write, registered read output.
    logic [15:0] rf_mem [8];
    always @(posedge clk) begin
        if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
        if (rf_read_enable)  rf_read_data <= rf_mem[rf_read_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard of expected read returns.
    typedef struct {
        int          due;
        int          port;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference model state, in plain integers.
    int          m_owner = -1;
    int          m_run   = 0;
    int          m_last  = 1;
    logic [15:0] smem [8];

    // Stimulus per port.
    logic        s_rst = 1'b1;
    logic        s_r  [2];
    logic        s_we [2];
    logic        s_lk [2];
    logic [2:0]  s_ad [2];
    logic [15:0] s_wd [2];
    int          win_p;

    task automatic set_port(input int p, input logic r, input logic w, input logic [2:0] a,
                            input logic [15:0] d, input logic l);
        s_r[p] = r; s_we[p] = w; s_ad[p] = a; s_wd[p] = d; s_lk[p] = l;
    endtask

    task automatic step();
        int w;
        rst = s_rst;
        req0 = s_r[0]; we0 = s_we[0]; addr0 = s_ad[0]; wdata0 = s_wd[0]; lock0 = s_lk[0];
        req1 = s_r[1]; we1 = s_we[1]; addr1 = s_ad[1]; wdata1 = s_wd[1]; lock1 = s_lk[1];
        #3;
        w = -1;
        if (s_rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due == cyc) sb.delete(i);
            m_owner = -1; m_run = 0; m_last = 1;
        end else begin
            if (m_owner >= 0 && s_r[m_owner])
                w = (m_run == MB && s_r[1 - m_owner]) ? 1 - m_owner : m_owner;
            else if (s_r[0] && s_r[1]) w = 1 - m_last;
            else if (s_r[0]) w = 0;
            else if (s_r[1]) w = 1;
        end
        chk("gnt0", gnt0, w == 0);
        chk("gnt1", gnt1, w == 1);
        if (w >= 0) begin
            chk("rf_write_enable", rf_write_enable, s_we[w]);
            chk("rf_read_enable", rf_read_enable, !s_we[w]);
            chk("rf_read_addr", rf_read_addr, s_ad[w]);
            chk("rf_write_addr", rf_write_addr, s_ad[w]);
            if (s_we[w]) begin
                chk("rf_write_data", rf_write_data, s_wd[w]);
                smem[s_ad[w]] = s_wd[w];
            end else begin
                sb.push_back('{due: cyc + 1, port: w, data: smem[s_ad[w]]});
            end
            if (s_lk[w]) begin
                m_run   = (m_owner == w) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
                m_owner = w;
            end else begin
                m_owner = -1; m_run = 0;
            end
            m_last = w;
        end else begin
            chk("rf_enables_idle", {rf_write_enable, rf_read_enable}, 2'b00);
            if (!s_rst) begin m_owner = -1; m_run = 0; end
        end
        win_p = w;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle compares read-return valids and data with the scoreboard.
    always @(negedge clk) begin
        int e0, e1;
        e0 = 0; e1 = 0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].port == 0) e0 = 1; else e1 = 1;
        end
        chk("rvalid0", rvalid0, e0);
        chk("rvalid1", rvalid1, e1);
        if (e0 == 1 || e1 == 1) begin
            chk(e0 == 1 ? "rdata0" : "rdata1", e0 == 1 ? rdata0 : rdata1, sb[0].data);
            void'(sb.pop_front());
        end
    end

    task automatic idle_all();
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        set_port(0, 1, 0, 3'd1, 16'h0, 0);
        set_port(1, 1, 0, 3'd2, 16'h0, 0);
        step(); step();
        s_rst = 1'b0;
        idle_all();
    endtask

    initial begin
        logic pend [2];
        for (int i = 0; i < 8; i++) begin
            rf_mem[i] = 16'h1000 + 16'(i * 16'h0101);
            smem[i]   = 16'h1000 + 16'(i * 16'h0101);
        end
        idle_all();
        @(posedge clk); #1;

        // Write then read back on port 0.
        do_reset();
        set_port(0, 1, 1, 3'd3, 16'hBEEF, 0); step();
        set_port(0, 1, 0, 3'd3, 16'h0, 0);    step();
        idle_all(); step();

        // Both ports reading every cycle, alternating grants.
        do_reset();
        set_port(0, 1, 0, 3'd1, 16'h0, 0);
        set_port(1, 1, 0, 3'd2, 16'h0, 0);
        repeat (6) step();
        idle_all(); step();

        // Port 0 locked writing, port 1 waiting: forced rotation after the burst.
        do_reset();
        set_port(0, 1, 1, 3'd5, 16'hA5A5, 1);
        set_port(1, 1, 1, 3'd6, 16'h5A5A, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (win_p == 1) s_r[1] = 1'b0;
        end
        idle_all(); step();

        // Port 1 locked alone for 10 cycles, then port 0 arrives.
        do_reset();
        set_port(1, 1, 0, 3'd4, 16'h0, 1);
        repeat (10) step();
        set_port(0, 1, 0, 3'd0, 16'h0, 0);
        step();
        idle_all(); step(); step();

        // Reset right after a port 1 read grant, then a tie after reset.
        do_reset();
        set_port(1, 1, 0, 3'd2, 16'h0, 0); step();
        idle_all(); s_rst = 1'b1; step();
        s_rst = 1'b0;
        set_port(0, 1, 0, 3'd1, 16'h0, 0);
        set_port(1, 1, 0, 3'd2, 16'h0, 0);
        step(); step();
        idle_all(); step();

        // Same-cycle write and read of address 7.
        do_reset();
        set_port(0, 1, 1, 3'd7, 16'h1234, 0);
        set_port(1, 1, 0, 3'd7, 16'h0, 0);
        step();
        s_r[0] = 1'b0;
        step();
        idle_all(); step();

        // Randomized traffic with requests held until granted.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        set_port(p, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                                 16'($urandom), 1'($urandom_range(0, 2) != 0));
                        pend[p] = 1'b1;
                    end else begin
                        set_port(p, 0, 0, 0, 0, 0);
                    end
                end
            end
            s_rst = ($urandom_range(0, 199) == 0);
            step();
            if (win_p >= 0) pend[win_p] = 1'b0;
        end
        s_rst = 1'b0;
        idle_all(); step(); step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
